// File: rtl/capture_seq_ctrl_if.sv
// UART byte-stream handshake between the capture sequencer and the uart_rx/uart_tx blocks.
// master = sequencer side, slave = UART/host side.
interface capture_seq_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_done;
  logic       tx_send;
  logic [7:0] tx_data;

  modport master (
    input  rx_data,
    input  rx_valid,
    input  tx_done,
    output tx_send,
    output tx_data
  );

  modport slave (
    output rx_data,
    output rx_valid,
    output tx_done,
    input  tx_send,
    input  tx_data
  );
endinterface

// File: rtl/capture_seq_ctrl.sv
// Host-command sequencer for the DPA capture loop: patch-window loading, target reset
// hammering with IPL-completion wait, and byte-wise result/dump reporting over the UART.
module capture_seq_ctrl #(
  parameter int RESET_CYCLES = 20000,
  parameter int RUN_TIMEOUT  = 5549995,
  parameter int LOAD_TIMEOUT = 1000000,
  parameter int CNT_W        = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  capture_seq_ctrl_if.master        uart,
  input  logic                      ipl_done,
  output logic                      reset_out,
  output logic                      trigger_arm,
  output logic [127:0]              patch_window,
  output logic                      patch_valid,
  output logic                      busy
);

  localparam logic [7:0] CMD_LOAD     = 8'h3A;
  localparam logic [7:0] CMD_RUN      = 8'h21;
  localparam logic [7:0] CMD_DUMP     = 8'h2A;
  localparam logic [7:0] RSP_LOADED   = 8'h4C;
  localparam logic [7:0] RSP_LOAD_ERR = 8'h45;
  localparam logic [7:0] RSP_IPL_OK   = 8'h4B;
  localparam logic [7:0] RSP_TIMEOUT  = 8'h54;

  // Counter compares against "last cycle" values so each phase spans exactly N cycles.
  localparam logic [CNT_W-1:0] HAMMER_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HAMMER,
    S_WAIT_IPL,
    S_REPORT,
    S_DUMP
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_idx;
  logic [7:0]       r_staging [16];
  logic [127:0]     r_patchWindow;
  logic             r_patchValid;
  logic             r_txSend;
  logic             r_txBusy;
  logic [7:0]       r_txData;

  logic             w_cntClr;
  logic             w_cntInc;
  logic             w_idxClr;
  logic             w_idxInc;
  logic             w_stageWr;
  logic             w_stageClr;
  logic             w_commit;
  logic             w_startTx;
  logic [7:0]       w_txByte;
  logic [7:0]       w_dumpByte;
  logic [127:0]     w_newWindow;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The 16th byte goes straight into the committed window, bypassing staging.
  always_comb begin
    w_newWindow = '0;
    for (int i = 0; i < 15; i++) begin
      w_newWindow[8*i +: 8] = r_staging[i];
    end
    w_newWindow[127:120] = uart.rx_data;
  end

  assign w_dumpByte = r_patchWindow[{r_idx[3:0], 3'b000} +: 8];

  always_comb begin
    w_nextState = r_state;
    w_cntClr    = 1'b0;
    w_cntInc    = 1'b0;
    w_idxClr    = 1'b0;
    w_idxInc    = 1'b0;
    w_stageWr   = 1'b0;
    w_stageClr  = 1'b0;
    w_commit    = 1'b0;
    w_startTx   = 1'b0;
    w_txByte    = '0;
    reset_out   = (r_state != S_HAMMER);
    trigger_arm = (r_state == S_WAIT_IPL);
    busy        = (r_state != S_IDLE);

    unique case (r_state)
      S_IDLE: begin
        if (uart.rx_valid) begin
          if (uart.rx_data == CMD_LOAD) begin
            w_nextState = S_LOAD;
            w_idxClr    = 1'b1;
            w_cntClr    = 1'b1;
            w_stageClr  = 1'b1;
          end else if (uart.rx_data == CMD_RUN) begin
            w_nextState = S_HAMMER;
            w_cntClr    = 1'b1;
          end else if (uart.rx_data == CMD_DUMP) begin
            w_nextState = S_DUMP;
            w_idxClr    = 1'b1;
          end
        end
      end

      // A byte arriving on the timeout cycle is taken, so rx_valid is checked first.
      S_LOAD: begin
        if (uart.rx_valid) begin
          w_cntClr = 1'b1;
          if (r_idx == 5'd15) begin
            w_commit    = 1'b1;
            w_idxClr    = 1'b1;
            w_startTx   = 1'b1;
            w_txByte    = RSP_LOADED;
            w_nextState = S_REPORT;
          end else begin
            w_stageWr = 1'b1;
            w_idxInc  = 1'b1;
          end
        end else if (r_cnt == LOAD_LAST) begin
          w_stageClr  = 1'b1;
          w_idxClr    = 1'b1;
          w_startTx   = 1'b1;
          w_txByte    = RSP_LOAD_ERR;
          w_nextState = S_REPORT;
        end else begin
          w_cntInc = 1'b1;
        end
      end

      S_HAMMER: begin
        if (r_cnt == HAMMER_LAST) begin
          w_cntClr    = 1'b1;
          w_nextState = S_WAIT_IPL;
        end else begin
          w_cntInc = 1'b1;
        end
      end

      S_WAIT_IPL: begin
        if (ipl_done) begin
          w_startTx   = 1'b1;
          w_txByte    = RSP_IPL_OK;
          w_nextState = S_REPORT;
        end else if (r_cnt == RUN_LAST) begin
          w_startTx   = 1'b1;
          w_txByte    = RSP_TIMEOUT;
          w_nextState = S_REPORT;
        end else begin
          w_cntInc = 1'b1;
        end
      end

      S_REPORT: begin
        if (r_txBusy && uart.tx_done) begin
          w_nextState = S_IDLE;
        end
      end

      // r_idx counts bytes already sent; the next one waits for the previous tx_done.
      S_DUMP: begin
        if (r_txBusy) begin
          if (uart.tx_done && (r_idx == 5'd16)) begin
            w_nextState = S_IDLE;
          end
        end else if (r_idx != 5'd16) begin
          w_startTx = 1'b1;
          w_txByte  = w_dumpByte;
          w_idxInc  = 1'b1;
        end
      end

      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_patchWindow <= '0;
      r_patchValid  <= 1'b0;
      r_txSend      <= 1'b0;
      r_txBusy      <= 1'b0;
      r_txData      <= '0;
      for (int i = 0; i < 16; i++) begin
        r_staging[i] <= '0;
      end
    end else begin
      if (w_cntClr) begin
        r_cnt <= '0;
      end else if (w_cntInc && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_ONE;
      end

      if (w_idxClr) begin
        r_idx <= '0;
      end else if (w_idxInc) begin
        r_idx <= r_idx + 5'd1;
      end

      if (w_stageClr) begin
        for (int i = 0; i < 16; i++) begin
          r_staging[i] <= '0;
        end
      end else if (w_stageWr) begin
        r_staging[r_idx[3:0]] <= uart.rx_data;
      end

      if (w_commit) begin
        r_patchWindow <= w_newWindow;
        r_patchValid  <= 1'b1;
      end

      r_txSend <= w_startTx;
      if (w_startTx) begin
        r_txData <= w_txByte;
        r_txBusy <= 1'b1;
      end else if (uart.tx_done) begin
        r_txBusy <= 1'b0;
      end
    end
  end

  assign uart.tx_send = r_txSend;
  assign uart.tx_data = r_txData;
  assign patch_window = r_patchWindow;
  assign patch_valid  = r_patchValid;

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Self-checking bench for capture_seq_ctrl: scenario tasks with randomized patches and
// IPL timing, checked against a byte-queue model of the host protocol.
module tb_capture_seq_ctrl;
  localparam int RC = 20;
  localparam int RT = 150;
  localparam int LT = 40;
  localparam int CW = 16;

  logic         clk;
  logic         rstn;
  logic         ipl_done;
  logic         reset_out;
  logic         trigger_arm;
  logic [127:0] patch_window;
  logic         patch_valid;
  logic         busy;

  capture_seq_ctrl_if u();

  capture_seq_ctrl #(
    .RESET_CYCLES(RC),
    .RUN_TIMEOUT (RT),
    .LOAD_TIMEOUT(LT),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .uart        (u),
    .ipl_done    (ipl_done),
    .reset_out   (reset_out),
    .trigger_arm (trigger_arm),
    .patch_window(patch_window),
    .patch_valid (patch_valid),
    .busy        (busy)
  );

  int           nChecks = 0;
  int           nFails = 0;
  int           txLat = 3;
  int           txViol = 0;
  bit           txOutstanding = 1'b0;
  logic [7:0]   captured[$];
  logic [127:0] modelWindow = '0;
  bit           modelValid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every transmitted byte and flags a send issued while one is outstanding.
  always @(negedge clk) begin
    if (rstn === 1'b1 && u.tx_send === 1'b1) begin
      if (txOutstanding) txViol++;
      txOutstanding = 1'b1;
      captured.push_back(u.tx_data);
    end
  end

  // Host-side UART transmitter: returns tx_done txLat cycles after each send.
  initial begin
    u.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (u.tx_send === 1'b1) begin
        repeat (txLat) @(posedge clk);
        #1 u.tx_done = 1'b1;
        @(posedge clk);
        #1 u.tx_done = 1'b0;
        txOutstanding = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    u.rx_data  = b;
    u.rx_valid = 1'b1;
    @(posedge clk);
    #1 u.rx_valid = 1'b0;
  endtask

  task automatic doReset();
    u.rx_valid = 1'b0;
    ipl_done   = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    captured.delete();
    txOutstanding = 1'b0;
    modelWindow = '0;
    modelValid  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic sendLoad(input logic [7:0] b[16], input int gapMax, input bit boundaryGap);
    sendByte(8'h3A);
    for (int i = 0; i < 16; i++) begin
      if (boundaryGap && i[0]) idle(LT - 1);
      else idle($urandom_range(0, gapMax));
      sendByte(b[i]);
    end
    for (int i = 0; i < 16; i++) modelWindow[8*i +: 8] = b[i];
    modelValid = 1'b1;
  endtask

  task automatic waitTx(input int n, input int limit, output bit ok);
    int c = 0;
    while (captured.size() < n && c < limit) begin
      @(negedge clk);
      c++;
    end
    ok = (captured.size() >= n);
  endtask

  task automatic waitIdle(input int limit, output bit ok);
    int c = 0;
    while (busy !== 1'b0 && c < limit) begin
      @(negedge clk);
      c++;
    end
    ok = (busy === 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic waitRelease(output int lowCnt, output int armInHammer);
    lowCnt = 0;
    armInHammer = 0;
    @(negedge clk);
    while (reset_out !== 1'b1 && lowCnt < RC + 50) begin
      lowCnt++;
      if (trigger_arm !== 1'b0) armInHammer++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    doReset();
    nChecks++; if (reset_out !== 1'b1) begin nFails++; $display("[TB] FAIL reset.reset_out got=%0h exp=1", reset_out); end
    nChecks++; if (trigger_arm !== 1'b0) begin nFails++; $display("[TB] FAIL reset.trigger_arm got=%0h exp=0", trigger_arm); end
    nChecks++; if (u.tx_send !== 1'b0) begin nFails++; $display("[TB] FAIL reset.tx_send got=%0h exp=0", u.tx_send); end
    nChecks++; if (u.tx_data !== 8'h00) begin nFails++; $display("[TB] FAIL reset.tx_data got=%0h exp=0", u.tx_data); end
    nChecks++; if (patch_window !== 128'h0) begin nFails++; $display("[TB] FAIL reset.patch_window got=%0h exp=0", patch_window); end
    nChecks++; if (patch_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset.patch_valid got=%0h exp=0", patch_valid); end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset.busy got=%0h exp=0", busy); end
  endtask

  task automatic test_load();
    logic [7:0] pat[16];
    bit ok;
    bit okIdle;
    for (int i = 0; i < 16; i++) pat[i] = 8'(i);
    captured.delete();
    sendLoad(pat, 0, 1'b0);
    waitTx(1, 100, ok);
    waitIdle(200, okIdle);
    nChecks++; if (!ok || !okIdle) begin nFails++; $display("[TB] FAIL load.done got=%0d%0d exp=11", ok, okIdle); end
    nChecks++; if (patch_window !== 128'h0F0E0D0C0B0A09080706050403020100) begin nFails++; $display("[TB] FAIL load.window got=%h exp=0f0e..0100", patch_window); end
    nChecks++; if (patch_valid !== 1'b1) begin nFails++; $display("[TB] FAIL load.valid got=%0h exp=1", patch_valid); end
    nChecks++; if (captured.size() != 1) begin nFails++; $display("[TB] FAIL load.txcount got=%0d exp=1", captured.size()); end
    nChecks++; if (captured.size() < 1 || captured[0] !== 8'h4C) begin nFails++; $display("[TB] FAIL load.code got=%p exp=4c", captured); end
  endtask

  task automatic test_load_timeout();
    int n;
    bit ok;
    captured.delete();
    sendByte(8'h3A);
    for (int i = 0; i < 5; i++) sendByte(8'($urandom));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (u.tx_send !== 1'b1 && n < LT + 20);
    waitIdle(200, ok);
    nChecks++; if (n < LT || n > LT + 1) begin nFails++; $display("[TB] FAIL load_timeout.latency got=%0d exp=%0d", n, LT); end
    nChecks++; if (captured.size() != 1 || captured[0] !== 8'h45) begin nFails++; $display("[TB] FAIL load_timeout.code got=%p exp=45", captured); end
    nChecks++; if (patch_window !== modelWindow) begin nFails++; $display("[TB] FAIL load_timeout.window got=%h exp=%h", patch_window, modelWindow); end
    nChecks++; if (!ok || patch_valid !== modelValid) begin nFails++; $display("[TB] FAIL load_timeout.idle got=%0d/%0h exp=1/%0h", ok, patch_valid, modelValid); end
  endtask

  task automatic test_load_gap_boundary();
    logic [7:0] pat[16];
    bit ok;
    bit okIdle;
    for (int i = 0; i < 16; i++) pat[i] = 8'($urandom);
    pat[3] = 8'h3A;
    pat[6] = 8'h00;
    captured.delete();
    sendLoad(pat, 3, 1'b1);
    waitTx(1, 100, ok);
    waitIdle(200, okIdle);
    nChecks++; if (!ok || captured[0] !== 8'h4C) begin nFails++; $display("[TB] FAIL gap_boundary.code got=%p exp=4c", captured); end
    nChecks++; if (patch_window !== modelWindow) begin nFails++; $display("[TB] FAIL gap_boundary.window got=%h exp=%h", patch_window, modelWindow); end
  endtask

  task automatic test_run_ok();
    int lowCnt;
    int armH;
    int armBad = 0;
    bit ok;
    bit okIdle;
    captured.delete();
    sendByte(8'h21);
    waitRelease(lowCnt, armH);
    nChecks++; if (lowCnt != RC) begin nFails++; $display("[TB] FAIL run_ok.hammer_len got=%0d exp=%0d", lowCnt, RC); end
    nChecks++; if (armH != 0) begin nFails++; $display("[TB] FAIL run_ok.arm_in_hammer got=%0d exp=0", armH); end
    if (trigger_arm !== 1'b1) armBad++;
    repeat (99) begin
      @(negedge clk);
      if (trigger_arm !== 1'b1 || reset_out !== 1'b1) armBad++;
    end
    @(posedge clk);
    #1 ipl_done = 1'b1;
    @(posedge clk);
    #1 ipl_done = 1'b0;
    nChecks++; if (armBad != 0) begin nFails++; $display("[TB] FAIL run_ok.arm_window got=%0d exp=0", armBad); end
    nChecks++; if (trigger_arm !== 1'b0) begin nFails++; $display("[TB] FAIL run_ok.arm_drop got=%0h exp=0", trigger_arm); end
    waitTx(1, 50, ok);
    waitIdle(100, okIdle);
    nChecks++; if (!ok || captured.size() != 1 || captured[0] !== 8'h4B) begin nFails++; $display("[TB] FAIL run_ok.code got=%p exp=4b", captured); end
    nChecks++; if (!okIdle) begin nFails++; $display("[TB] FAIL run_ok.idle got=%0h exp=0", busy); end
  endtask

  task automatic test_run_timeout();
    int lowCnt;
    int armH;
    int n;
    bit ok;
    bit okIdle;
    logic [7:0] expCode;
    for (int v = 0; v < 3; v++) begin
      captured.delete();
      sendByte(8'h21);
      waitRelease(lowCnt, armH);
      if (v == 0) begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (u.tx_send !== 1'b1 && n < RT + 20);
        nChecks++; if (n != RT) begin nFails++; $display("[TB] FAIL run_timeout.latency got=%0d exp=%0d", n, RT); end
        expCode = 8'h54;
      end else begin
        repeat ((v == 1) ? RT - 1 : RT) @(negedge clk);
        ipl_done = 1'b1;
        @(posedge clk);
        #1 ipl_done = 1'b0;
        expCode = (v == 1) ? 8'h4B : 8'h54;
      end
      waitTx(1, RT + 40, ok);
      waitIdle(100, okIdle);
      nChecks++; if (!ok || !okIdle || captured.size() != 1 || captured[0] !== expCode) begin nFails++; $display("[TB] FAIL run_timeout.code[%0d] got=%p exp=%h", v, captured, expCode); end
    end
  endtask

  task automatic test_dump(input bit fixedPattern, input int lat);
    logic [7:0] pat[16];
    bit ok;
    bit okIdle;
    int bad = 0;
    for (int i = 0; i < 16; i++) pat[i] = fixedPattern ? 8'(8'hA0 + i) : 8'($urandom);
    sendLoad(pat, 4, 1'b0);
    waitTx(1, 100, ok);
    waitIdle(200, okIdle);
    captured.delete();
    txLat = lat;
    txViol = 0;
    sendByte(8'h2A);
    waitTx(16, 16 * (lat + 10), ok);
    waitIdle(lat + 20, okIdle);
    txLat = 3;
    for (int i = 0; i < 16; i++) begin
      if (i >= captured.size() || captured[i] !== modelWindow[8*i +: 8]) bad++;
    end
    nChecks++; if (!ok || captured.size() != 16) begin nFails++; $display("[TB] FAIL dump.count got=%0d exp=16", captured.size()); end
    nChecks++; if (bad != 0) begin nFails++; $display("[TB] FAIL dump.bytes got=%p exp=%h", captured, modelWindow); end
    nChecks++; if (txViol != 0) begin nFails++; $display("[TB] FAIL dump.overlap got=%0d exp=0", txViol); end
    nChecks++; if (!okIdle) begin nFails++; $display("[TB] FAIL dump.idle got=%0h exp=0", busy); end
  endtask

  task automatic test_drop();
    int lowCnt;
    int armH;
    bit ok;
    bit okIdle;
    captured.delete();
    sendByte(8'h21);
    sendByte(8'h2A);
    sendByte(8'h3A);
    waitRelease(lowCnt, armH);
    @(posedge clk);
    #1;
    sendByte(8'h3A);
    sendByte(8'h2A);
    sendByte(8'h21);
    waitTx(1, RT + 40, ok);
    waitIdle(100, okIdle);
    idle(10);
    nChecks++; if (!ok || captured.size() != 1 || captured[0] !== 8'h54) begin nFails++; $display("[TB] FAIL drop.code got=%p exp=54", captured); end
    nChecks++; if (patch_window !== modelWindow || busy !== 1'b0) begin nFails++; $display("[TB] FAIL drop.state got=%h/%0h exp=%h/0", patch_window, busy, modelWindow); end
  endtask

  task automatic test_random_runs();
    int lowCnt;
    int armH;
    int d;
    bit ok;
    bit okIdle;
    logic [7:0] expCode;
    for (int k = 0; k < 6; k++) begin
      d = $urandom_range(0, RT + 20);
      expCode = (d <= RT - 1) ? 8'h4B : 8'h54;
      captured.delete();
      sendByte(8'h21);
      waitRelease(lowCnt, armH);
      repeat (d) @(negedge clk);
      ipl_done = 1'b1;
      waitTx(1, RT + 40, ok);
      ipl_done = 1'b0;
      waitIdle(100, okIdle);
      nChecks++; if (!ok || !okIdle || captured.size() != 1 || captured[0] !== expCode) begin nFails++; $display("[TB] FAIL random_run[d=%0d] got=%p exp=%h", d, captured, expCode); end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] pat[16];
    bit ok;
    bit okIdle;
    sendByte(8'h21);
    idle(5);
    @(negedge clk);
    nChecks++; if (reset_out !== 1'b0) begin nFails++; $display("[TB] FAIL async.in_hammer got=%0h exp=0", reset_out); end
    rstn = 1'b0;
    #1;
    nChecks++; if (reset_out !== 1'b1 || busy !== 1'b0 || patch_valid !== 1'b0 || patch_window !== 128'h0) begin nFails++; $display("[TB] FAIL async.hammer got=%0h%0h%0h exp=100", reset_out, busy, patch_valid); end
    doReset();
    for (int i = 0; i < 16; i++) pat[i] = 8'($urandom);
    sendLoad(pat, 2, 1'b0);
    waitTx(1, 100, ok);
    waitIdle(200, okIdle);
    sendByte(8'h3A);
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h33);
    idle(2);
    @(negedge clk);
    nChecks++; if (busy !== 1'b1 || patch_valid !== 1'b1) begin nFails++; $display("[TB] FAIL async.in_load got=%0h%0h exp=11", busy, patch_valid); end
    rstn = 1'b0;
    #1;
    nChecks++; if (busy !== 1'b0 || patch_valid !== 1'b0 || patch_window !== 128'h0 || reset_out !== 1'b1) begin nFails++; $display("[TB] FAIL async.load got=%0h%0h%h exp=00,0", busy, patch_valid, patch_window); end
    doReset();
    for (int i = 0; i < 16; i++) pat[i] = 8'($urandom);
    sendLoad(pat, 2, 1'b0);
    waitTx(1, 100, ok);
    waitIdle(200, okIdle);
    nChecks++; if (!ok || patch_window !== modelWindow) begin nFails++; $display("[TB] FAIL async.reload got=%h exp=%h", patch_window, modelWindow); end
  endtask

  initial begin
    rstn       = 1'b0;
    ipl_done   = 1'b0;
    u.rx_valid = 1'b0;
    u.rx_data  = 8'h00;
    test_reset();
    test_load();
    test_load_timeout();
    test_load_gap_boundary();
    test_run_ok();
    test_run_timeout();
    test_dump(1'b1, 50);
    test_dump(1'b0, $urandom_range(1, 6));
    test_drop();
    test_random_runs();
    test_async_reset();
    nChecks++; if (txViol != 0) begin nFails++; $display("[TB] FAIL tx_overlap got=%0d exp=0", txViol); end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
